// File: rtl/pe_arr_sequencer.sv
// Sequencer for one ROWS x COLS systolic PE array tile pass: reads K operand
// vectors, skews them onto the array edges, fires PE(0,0), waits for drain, pulses done.
//
// state | meaning
// IDLE  | waiting for start; all outputs quiet
// ISSUE | one buffer read per cycle, rd_addr = 0..K-1
// DRAIN | reads finished, wavefront still travelling through the array
// DONE  | one-cycle done pulse, start ignored

module pe_skew_lane #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       flush,
    input  logic [7:0] lane_in,
    output logic [7:0] lane_out
);
    logic [7:0] pipe [DEPTH];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn || flush) begin
            for (int k = 0; k < DEPTH; k++) pipe[k] <= 8'h00;
        end else begin
            pipe[0] <= lane_in;
            for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign lane_out = pipe[DEPTH-1];
endmodule

module pe_arr_sequencer #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int KW     = 8,
    parameter int AW     = 8,
    parameter int PE_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [KW-1:0]        k_len,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic [COLS*8-1:0]    w_rdata,
    input  logic [ROWS*8-1:0]    a_rdata,
    output logic [COLS*8-1:0]    pe_w,
    output logic [ROWS*8-1:0]    pe_a,
    output logic                 pe_fire
);
    localparam int DRAIN_CYC = ROWS + COLS - 1 + PE_LAT;
    localparam int DW        = $clog2(ROWS + COLS + PE_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state;
    logic [KW-1:0] step;
    logic [KW-1:0] k_lat;
    logic [DW-1:0] drain_cnt;
    logic          rd_valid;
    logic          flush;

    assign flush   = abort && (state != IDLE);
    assign rd_addr = AW'(step);

    // DRAIN lasts DRAIN_CYC-1 cycles so done lands DRAIN_CYC cycles after the last read
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state     <= IDLE;
            step      <= '0;
            k_lat     <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            pe_fire   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            step      <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            pe_fire   <= 1'b0;
        end else begin
            done    <= 1'b0;
            pe_fire <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_lat <= k_len;
                        step  <= '0;
                        if (k_len != '0) begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                            rd_en <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    pe_fire <= (step == '0);
                    if (step == k_lat - 1'b1) begin
                        state     <= DRAIN;
                        rd_en     <= 1'b0;
                        step      <= '0;
                        drain_cnt <= DW'(DRAIN_CYC - 2);
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)       rd_valid <= 1'b0;
        else if (flush) rd_valid <= 1'b0;
        else            rd_valid <= rd_en;
    end

    // Lane data is gated by rd_valid so idle bus contents never enter the skew pipes
    for (genvar j = 0; j < COLS; j++) begin : g_w
        logic [7:0] w_in;
        assign w_in = rd_valid ? w_rdata[8*j +: 8] : 8'h00;
        if (j == 0) begin : g_direct
            assign pe_w[7:0] = w_in;
        end else begin : g_skew
            pe_skew_lane #(.DEPTH(j)) u_lane (
                .clk      (clk),
                .rstn     (rstn),
                .flush    (flush),
                .lane_in  (w_in),
                .lane_out (pe_w[8*j +: 8])
            );
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_a
        logic [7:0] a_in;
        assign a_in = rd_valid ? a_rdata[8*i +: 8] : 8'h00;
        if (i == 0) begin : g_direct
            assign pe_a[7:0] = a_in;
        end else begin : g_skew
            pe_skew_lane #(.DEPTH(i)) u_lane (
                .clk      (clk),
                .rstn     (rstn),
                .flush    (flush),
                .lane_in  (a_in),
                .lane_out (pe_a[8*i +: 8])
            );
        end
    end
endmodule

// File: tb/tb_pe_arr_sequencer.sv
// Directed bench for pe_arr_sequencer: per-cycle expected outputs from a
// buffer/skew model, plus a 4x4 systolic product check on the first pass.

module tb_pe_arr_sequencer;
    localparam int ROWS = 4, COLS = 4, KW = 8, AW = 8, PE_LAT = 1;
    localparam int DRN  = ROWS + COLS - 1 + PE_LAT;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic            busy, done, rd_en, pe_fire;
    logic [AW-1:0]   rd_addr;
    logic [31:0]     w_rdata, a_rdata, pe_w, pe_a;

    logic [31:0] mem_w [256];
    logic [31:0] mem_a [256];
    logic [31:0] hist_w [0:299];
    logic [31:0] hist_a [0:299];

    int n_chk = 0;
    int n_bad = 0;
    int cur_t = 0;

    pe_arr_sequencer #(.ROWS(ROWS), .COLS(COLS), .KW(KW), .AW(AW), .PE_LAT(PE_LAT)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .k_len(k_len),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .w_rdata(w_rdata), .a_rdata(a_rdata), .pe_w(pe_w), .pe_a(pe_a), .pe_fire(pe_fire)
    );

    always #5 clk = ~clk;

    // Operand buffers: one-cycle read latency, junk on the bus when not read
    always @(posedge clk) begin
        w_rdata <= rd_en ? mem_w[rd_addr] : 32'hA5A5_5A5A;
        a_rdata <= rd_en ? mem_a[rd_addr] : 32'h3C3C_C3C3;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, cur_t, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk_eq({tag, "_ctl"}, {20'b0, busy, done, rd_en, pe_fire, rd_addr}, 32'h0);
        chk_eq({tag, "_w"}, pe_w, 32'h0);
        chk_eq({tag, "_a"}, pe_a, 32'h0);
    endtask

    // Cycle 0 is the acceptance cycle; kill_t is the last live cycle before abort/reset
    task automatic run_pass(input int k, input int ncyc, input int kill_t,
                            input bit kill_rst, input bit hold, input bit ab0);
        logic [31:0] ew, ea;
        bit live;
        int s;
        @(negedge clk);
        cur_t = 0;
        chk_eq("idle_busy", {31'b0, busy}, 32'h0);
        start = 1'b1;
        k_len = KW'(k);
        abort = ab0;
        for (int t = 1; t <= ncyc; t++) begin
            @(negedge clk);
            cur_t = t;
            start = hold;
            abort = !kill_rst && (t == kill_t);
            if (hold) k_len = KW'(t);
            live = (kill_t == 0) || (t <= kill_t);
            ew = '0;
            ea = '0;
            for (int j = 0; j < 4; j++) begin
                s = t - 2 - j;
                if (live && s >= 0 && s < k) begin
                    ew[8*j +: 8] = mem_w[s][8*j +: 8];
                    ea[8*j +: 8] = mem_a[s][8*j +: 8];
                end
            end
            chk_eq("rd_en",   {31'b0, rd_en},   {31'b0, live && t <= k});
            chk_eq("rd_addr", {24'b0, rd_addr}, (live && t <= k) ? t - 1 : 0);
            chk_eq("fire",    {31'b0, pe_fire}, {31'b0, live && k > 0 && t == 2});
            chk_eq("busy",    {31'b0, busy},    {31'b0, live && k > 0 && t < k + DRN});
            chk_eq("done",    {31'b0, done},    {31'b0, live && t == ((k == 0) ? 1 : k + DRN)});
            chk_eq("pe_w", pe_w, ew);
            chk_eq("pe_a", pe_a, ea);
            hist_w[t] = pe_w;
            hist_a[t] = pe_a;
            if (kill_rst && t == kill_t) begin
                #2 rstn = 1'b1;
                #1 chk_quiet("async_rst");
                #1 rstn = 1'b0;
            end
        end
        abort = 1'b0;
    endtask

    initial begin
        int acc, gold;
        for (int s = 0; s < 256; s++) begin
            for (int j = 0; j < 4; j++) begin
                mem_w[s][8*j +: 8] = 8'(s * 7 + j * 29 + 1);
                mem_a[s][8*j +: 8] = 8'(s * 13 + j * 41 + 5);
            end
        end
        for (int t = 0; t < 300; t++) begin
            hist_w[t] = '0;
            hist_a[t] = '0;
        end

        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rstn = 1'b0;

        // K=8 pass, then the array product it feeds
        run_pass(8, 20, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                acc  = 0;
                gold = 0;
                for (int t = 1; t <= 20 + ROWS + COLS; t++) begin
                    if (t - j >= 1 && t - i >= 1 && t - j <= 20 && t - i <= 20)
                        acc += int'(hist_a[t-j][8*i +: 8]) * int'(hist_w[t-i][8*j +: 8]);
                end
                for (int k = 0; k < 8; k++)
                    gold += int'(mem_a[k][8*i +: 8]) * int'(mem_w[k][8*j +: 8]);
                cur_t = i * 4 + j;
                chk_eq("matmul", acc, gold);
            end
        end

        run_pass(0, 4, 0, 1'b0, 1'b0, 1'b0);

        // start held high: second pass accepted in the first IDLE cycle after done
        run_pass(8, 8 + DRN, 0, 1'b0, 1'b1, 1'b0);
        run_pass(8, 20, 0, 1'b0, 1'b0, 1'b0);

        // abort in cycle 5, then start+abort together in IDLE
        run_pass(8, 20, 5, 1'b0, 1'b0, 1'b0);
        run_pass(8, 20, 0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset pulse in DRAIN
        run_pass(8, 20, 11, 1'b1, 1'b0, 1'b0);
        run_pass(8, 20, 0, 1'b0, 1'b0, 1'b0);

        run_pass(255, 255 + DRN + 2, 0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0d", cur_t);
        $fatal(1, "bench timeout");
    end
endmodule
